// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREAD-port integer register file with two writeback
// ports (ALU, LSU) and a per-register busy scoreboard for RAW/WAW detection.
// x0 is hardwired to zero and is never marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data and busy-clear to the read ports and to issue_ready.
module regfile_scoreboard #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic [1:0]            wb_valid,
  input  logic [2*AW-1:0]       wb_addr,
  input  logic [2*XLEN-1:0]     wb_data,
  input  logic                  flush,
  output logic [AW:0]           busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wb_hit0;   // one-hot: port 0 writes register r this cycle
  logic [NREGS-1:0] wb_hit1;   // one-hot: port 1 writes register r this cycle
  logic             wb_hit_rd; // issue_rd is being written back this cycle
  logic             issue_fire;
  logic [AW-1:0]    rd_addr [NREAD];

  // Decode both writeback ports into per-register hit vectors; x0 never hits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wb_hit0 = '0;
    wb_hit1 = '0;
    for (int r = 1; r < NREGS; r++) begin
      wb_hit0[r] = wb_valid[0] && (wb_addr[0 +: AW] == AW'(r));
      wb_hit1[r] = wb_valid[1] && (wb_addr[AW +: AW] == AW'(r));
    end
  end

  // Issue handshake: WAW stall on a busy destination, no accept during flush.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    wb_hit_rd = wb_hit0[issue_rd] | wb_hit1[issue_rd];
`else
    wb_hit_rd = 1'b0;
`endif
    issue_ready = !rst_n ||
                  (!flush && ((issue_rd == '0) || !busy[issue_rd] || wb_hit_rd));
    issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
  end

  // Next busy vector: flush clears all; otherwise writeback clears and an
  // accepted issue sets, with the issue winning on the same register.
  always_comb begin
    busy_nxt = busy & ~(wb_hit0 | wb_hit1);
    if (flush) begin
      busy_nxt = '0;
    end else if (issue_fire) begin
      busy_nxt[issue_rd] = 1'b1;
    end
  end

  // Register array and scoreboard state; port 1 wins a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset because reads of unwritten registers must
      // return zero; this costs a reset net per flop but is architectural.
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      for (int r = 1; r < NREGS; r++) begin
        if (wb_hit1[r]) begin
          regs[r] <= wb_data[XLEN +: XLEN];
        end else if (wb_hit0[r]) begin
          regs[r] <= wb_data[0 +: XLEN];
        end
      end
      busy <= busy_nxt;
    end
  end

  // Combinational read ports, optionally forwarding same-cycle writebacks.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr[i] = rs_addr[i*AW +: AW];
      rs_data[i*XLEN +: XLEN] = regs[rd_addr[i]];
      rs_busy[i]              = busy[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      if (wb_hit1[rd_addr[i]]) begin
        rs_data[i*XLEN +: XLEN] = wb_data[XLEN +: XLEN];
        rs_busy[i]              = issue_fire && (issue_rd == rd_addr[i]);
      end else if (wb_hit0[rd_addr[i]]) begin
        rs_data[i*XLEN +: XLEN] = wb_data[0 +: XLEN];
        rs_busy[i]              = issue_fire && (issue_rd == rd_addr[i]);
      end
`endif
      if (rd_addr[i] == '0 || !rst_n) begin
        rs_data[i*XLEN +: XLEN] = '0;
        rs_busy[i]              = 1'b0;
      end
    end
  end

  // Population count of the registered busy bits.
  always_comb begin
    busy_count = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_count = busy_count + (AW+1)'(busy[r]);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic, all compared against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic [1:0]            wb_valid;
  logic [2*AW-1:0]       wb_addr;
  logic [2*XLEN-1:0]     wb_data;
  logic                  flush;
  logic [AW:0]           busy_count;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data),
    .rs_busy(rs_busy), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .busy_count(busy_count)
  );

  // Reference model: architectural register values and busy flags.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              n_pass  = 0;
  int              n_total = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic bit wb_writes(input int p, input int a);
    return a != 0 && wb_valid[p] && int'(wb_addr[p*AW +: AW]) == a;
  endfunction

  function automatic bit m_ready();
    if (flush) return 1'b0;
    if (issue_rd == 0 || !m_busy[issue_rd]) return 1'b1;
    return BYP && (wb_writes(0, int'(issue_rd)) || wb_writes(1, int'(issue_rd)));
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (BYP && wb_writes(1, a)) return wb_data[XLEN +: XLEN];
    if (BYP && wb_writes(0, a)) return wb_data[0 +: XLEN];
    return m_regs[a];
  endfunction

  function automatic bit m_rs_busy(input int a);
    if (a == 0) return 1'b0;
    if (BYP && (wb_writes(0, a) || wb_writes(1, a)))
      return issue_valid && m_ready() && int'(issue_rd) == a;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = '0;
    wb_addr     = '0;
    wb_data     = '0;
    flush       = 1'b0;
  endtask

  task automatic set_wb(input int p, input int a, input logic [XLEN-1:0] d);
    wb_valid[p]            = 1'b1;
    wb_addr[p*AW +: AW]    = AW'(a);
    wb_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_reads(input int a0, input int a1);
    rs_addr = {AW'(a1), AW'(a0)};
  endtask

  // Check every output against the model, then clock and update the model.
  task automatic step();
    bit              acc;
    int              a;
    logic [XLEN-1:0] nregs [NREGS];
    bit              nbusy [NREGS];
    #1;
    for (int i = 0; i < NREAD; i++) begin
      a = int'(rs_addr[i*AW +: AW]);
      check($sformatf("rs_data%0d x%0d", i, a), rs_data[i*XLEN +: XLEN], m_read(a));
      check($sformatf("rs_busy%0d x%0d", i, a), rs_busy[i], m_rs_busy(a));
    end
    check("issue_ready", issue_ready, m_ready());
    check("busy_count", busy_count, m_count());
    acc = issue_valid && m_ready() && issue_rd != 0;
    for (int r = 0; r < NREGS; r++) begin
      nregs[r] = m_regs[r];
      nbusy[r] = m_busy[r];
    end
    for (int p = 0; p < 2; p++) begin
      a = int'(wb_addr[p*AW +: AW]);
      if (wb_writes(p, a)) begin
        nregs[a] = wb_data[p*XLEN +: XLEN];
        nbusy[a] = 1'b0;
      end
    end
    if (acc) nbusy[issue_rd] = 1'b1;
    if (flush) for (int r = 0; r < NREGS; r++) nbusy[r] = 1'b0;
    @(posedge clk);
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = nregs[r];
      m_busy[r] = nbusy[r];
    end
    #1;
  endtask

  task automatic issue(input int rd);
    idle();
    issue_valid = 1'b1;
    issue_rd    = AW'(rd);
    step();
  endtask

  initial begin
    idle();
    set_reads(0, 1);
    model_reset();
    #2;
    check("reset rs_data", rs_data, '0);
    check("reset rs_busy", rs_busy, '0);
    check("reset busy_count", busy_count, '0);
    check("reset issue_ready", issue_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All registers read zero after reset.
    for (int r = 0; r < NREGS; r += 2) begin
      set_reads(r, r + 1);
      step();
    end

    // x0 is hardwired.
    set_wb(0, 0, 64'hDEAD);
    step();
    idle();
    set_reads(0, 0);
    step();

    // Issue then writeback x5.
    issue(5);
    idle();
    set_reads(5, 0);
    step();
    set_wb(0, 5, 64'h1234);
    step();
    idle();
    #1;
    check("x5 after wb", rs_data[0 +: XLEN], 64'h1234);
    check("x5 busy after wb", rs_busy[0], 1'b0);
    step();

    // WAW stall on busy x7, then stall coincident with its writeback.
    issue(7);
    issue_valid = 1'b1;
    issue_rd    = 7;
    set_reads(7, 5);
    #1;
    check("waw stall ready", issue_ready, 1'b0);
    step();
    set_wb(1, 7, 64'h7777);
    step();
    idle();
    step();

    // Both ports write x3: port 1 wins.
    set_wb(0, 3, 64'hAA);
    set_wb(1, 3, 64'hBB);
    step();
    idle();
    set_reads(3, 9);
    #1;
    check("x3 port1 wins", rs_data[0 +: XLEN], 64'hBB);
    step();

    // Issue x9 with concurrent writeback to x9: issue wins.
    issue_valid = 1'b1;
    issue_rd    = 9;
    set_wb(0, 9, 64'h99);
    step();
    idle();
    #1;
    check("x9 issue wins busy", rs_busy[1], 1'b1);
    step();

    // Issue x1, x2, x4, then flush with a concurrent wb to x2.
    issue(1);
    issue(2);
    issue(4);
    idle();
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = 6;
    set_wb(0, 2, 64'h55);
    set_reads(2, 6);
    #1;
    check("flush blocks issue", issue_ready, 1'b0);
    step();
    idle();
    #1;
    check("flush busy_count", busy_count, '0);
    check("x2 wb during flush", rs_data[0 +: XLEN], 64'h55);
    step();

    // Asynchronous reset mid-operation.
    issue(10);
    issue(11);
    issue(12);
    idle();
    set_wb(0, 13, 64'hCAFE);
    step();
    idle();
    issue_rd = 10;
    set_reads(13, 10);
    #1;
    check("pre-reset busy_count", busy_count, 3);
    rst_n = 1'b0;
    #1;
    check("async rs_data", rs_data, '0);
    check("async rs_busy", rs_busy, '0);
    check("async busy_count", busy_count, '0);
    check("async issue_ready", issue_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    set_reads(11, 12);
    step();

    // Random traffic, biased to a few registers to provoke collisions.
    for (int n = 0; n < 800; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREGS - 1)
                                                  : $urandom_range(0, 7));
      wb_valid    = 2'($urandom_range(0, 3));
      wb_addr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wb_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
      flush       = ($urandom_range(0, 15) == 0);
      set_reads($urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with an integrated scoreboard for the pipelined core. It succeeds the single-write, two-read register file. It provides NREAD read ports and two writeback ports (ALU and load/store unit), and tracks a per-register busy bit from issue to writeback so the issue stage can detect RAW and WAW hazards. It sits between decode/issue and the writeback stage.

## Interface
- XLEN, 64, data width per register
- NREGS, 32, number of architectural registers, power of two >= 2; AW = $clog2(NREGS)
- NREAD, 2, number of read ports, 1..4
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- rs_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rs_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rs_busy  out  NREAD  busy bit of each read address
- issue_valid  in  1  request to mark issue_rd busy
- issue_rd  in  AW  destination register of the issuing instruction
- issue_ready  out  1  issue may be accepted this cycle
- wb_valid  in  2  writeback strobe per port
- wb_addr  in  2*AW  writeback addresses
- wb_data  in  2*XLEN  writeback data
- flush  in  1  clear all busy bits (pipeline squash)
- busy_count  out  AW+1  number of busy registers

## Operation
- State: regs[NREGS] of XLEN bits, and busy[NREGS].
- Reset (async, rst_n=0): all regs = 0, all busy = 0. Outputs while in reset: rs_data = 0, rs_busy = 0, busy_count = 0, issue_ready = 1.
- Register 0 is hardwired:
  - Reads return 0.
  - Writes to it are dropped.
  - busy[0] is never set.
  - rs_busy for address 0 is always 0.
- Issue accept: issue_valid & issue_ready.
  - issue_ready = !flush & (issue_rd == 0 | !busy[issue_rd]). This is a WAW stall.
  - On accept with issue_rd != 0: busy[issue_rd] <= 1.
- Writeback, port p with wb_valid[p] and wb_addr != 0:
  - regs[wb_addr] <= wb_data.
  - busy[wb_addr] <= 0.
  - A writeback to a non-busy register is legal; data is still written.
- Both writeback ports to the same address: port 1 wins the data; busy clears.
- Accepted issue and writeback to the same register in the same cycle: the issue wins, so busy ends at 1 and the data is written.
- flush: all busy <= 0 on the next edge. Writebacks in the same cycle still write data. No issue is accepted during flush.
- busy_count = popcount(busy), combinational from state.

## Timing
- Reads are combinational from state (zero latency).
- Writes are visible on the read ports the cycle after wb_valid.
- Busy set and clear take effect at the next edge.
- issue_ready is combinational from issue_rd, flush and busy. It does not depend on issue_valid.
- rs_busy without bypass reflects the registered busy bits only.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read address matching a same-cycle valid writeback (nonzero address) returns wb_data combinationally, with port 1 taking priority.
  - rs_busy for that read is 0, unless an accepted issue to the same register occurs in the same cycle, in which case it is 1.
  - issue_ready also treats a register being written back this cycle as not busy.
- REGFILE_BYPASS_EN undefined:
  - Reads and rs_busy see pre-edge state only.
  - A same-cycle writeback is invisible until the next cycle.

## Test plan
- Reset, then read all registers → rs_data = 0, rs_busy = 0, busy_count = 0. Write x0 = 0xDEAD, then read x0 → 0.
- Issue x5, then read x5 → rs_busy = 1, busy_count = 1. wb port 0 writes x5 = 0x1234 → next cycle rs_data = 0x1234, rs_busy = 0, busy_count = 0.
- x7 busy, issue_valid with issue_rd = 7 → issue_ready = 0 and busy_count unchanged. Same cycle, wb x7 → issue_ready = 1 only with REGFILE_BYPASS_EN.
- Both wb ports target x3 (port 0 = 0xAA, port 1 = 0xBB) → x3 = 0xBB. Accepted issue x9 plus wb x9 in the same cycle → busy[9] = 1 afterwards.
- Issue x1, x2, x4, then flush with a concurrent wb x2 = 0x55 → busy_count = 0 next cycle, x2 = 0x55, issue_ready = 0 during the flush cycle.
- Assert rst_n mid-operation with busy_count = 3 and nonzero regs → outputs are 0 immediately (asynchronous), state is cleared after release.
